// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM controller.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH_ADDR = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC_DP    = 4'd4,
    S_EXEC_ADDR  = 4'd5,
    S_MEM_WAIT   = 4'd6,
    S_WRITEBACK  = 4'd7,
    S_BRANCH     = 4'd8
  } state_t;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;

  localparam logic [1:0] BSEL_SHIFT = 2'b00;
  localparam logic [1:0] BSEL_IMM   = 2'b01;
  localparam logic [1:0] BSEL_PC    = 2'b10;

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator: cond field against NZCV. NV never passes.
module arm_cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_control_unit.sv
// Multi-cycle controller for the ARM datapath: fetch, decode, execute,
// memory and writeback sequencing driven from IR and NZCV.
//
//  state       | meaning
//  RESET       | held in reset, all strobes low
//  FETCH_ADDR  | PC -> MAR
//  FETCH_WAIT  | instruction read; on ack load IR and PC+4
//  DECODE      | condition check and class decode
//  EXEC_DP     | data-processing ALU op
//  EXEC_ADDR   | base +/- imm12 -> MAR
//  MEM_WAIT    | data read/write until ack
//  WRITEBACK   | MDR -> Rd
//  BRANCH      | PC <- target, optional link into R14
module arm_control_unit
  import arm_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] ir,
  input  logic [3:0]  flags,
  input  logic        mem_ack,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        rf_ld,
  output logic        flags_ld,
  output logic [1:0]  pc_sel,
  output logic        rf_wsel,
  output logic        rf_dsel,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_bsel,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_byte,
  output logic [3:0]  state_o,
  output logic        illegal
);

  state_t state, state_nxt;
  logic   cond_pass, cond_nv;
  logic   is_dp, is_ls, is_br, bad_class;
  logic   dp_test;
  logic   unused_ir;

  arm_cond_check u_cond (
    .cond  (ir[31:28]),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign cond_nv   = (ir[31:28] == COND_NV);
  assign is_dp     = (ir[27:26] == 2'b00);
  assign is_ls     = (ir[27:25] == 3'b010) & ir[24];
  assign is_br     = (ir[27:25] == 3'b101);
  assign bad_class = ~(is_dp | is_ls | is_br);
  assign dp_test   = (ir[24:21] >= OP_TST) && (ir[24:21] <= OP_CMN);
  assign unused_ir = ^ir[19:0];

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= S_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:      state_nxt = S_FETCH_ADDR;
      S_FETCH_ADDR: state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (cond_nv || !cond_pass || bad_class) state_nxt = S_FETCH_ADDR;
        else if (is_dp)                         state_nxt = S_EXEC_DP;
        else if (is_ls)                         state_nxt = S_EXEC_ADDR;
        else                                    state_nxt = S_BRANCH;
      end
      S_EXEC_DP:    state_nxt = S_FETCH_ADDR;
      S_EXEC_ADDR:  state_nxt = S_MEM_WAIT;
      S_MEM_WAIT:   if (mem_ack) state_nxt = ir[20] ? S_WRITEBACK : S_FETCH_ADDR;
      S_WRITEBACK:  state_nxt = S_FETCH_ADDR;
      S_BRANCH:     state_nxt = S_FETCH_ADDR;
      default:      state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    mar_ld   = 1'b0;
    mdr_ld   = 1'b0;
    rf_ld    = 1'b0;
    flags_ld = 1'b0;
    pc_sel   = PC_SEL_INC;
    rf_wsel  = 1'b0;
    rf_dsel  = 1'b0;
    alu_op   = OP_AND;
    alu_bsel = BSEL_SHIFT;
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    mem_byte = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH_ADDR: begin
        mar_ld   = 1'b1;
        alu_bsel = BSEL_PC;
      end
      S_FETCH_WAIT: begin
        mem_en = 1'b1;
        mem_rw = 1'b1;
        ir_ld  = mem_ack;
        pc_ld  = mem_ack;
      end
      // NV is always reported; other bad classes only when the condition holds
      S_DECODE: illegal = cond_nv | (cond_pass & bad_class);
      S_EXEC_DP: begin
        alu_op   = ir[24:21];
        rf_ld    = ~dp_test;
        flags_ld = ir[20] | dp_test;
      end
      S_EXEC_ADDR: begin
        alu_op   = ir[23] ? OP_ADD : OP_SUB;
        alu_bsel = BSEL_IMM;
        mar_ld   = 1'b1;
      end
      S_MEM_WAIT: begin
        mem_en   = 1'b1;
        mem_rw   = ir[20];
        mem_byte = ir[22];
        mdr_ld   = ir[20];
      end
      S_WRITEBACK: begin
        rf_ld   = 1'b1;
        rf_dsel = 1'b1;
      end
      S_BRANCH: begin
        pc_ld  = 1'b1;
        pc_sel = PC_SEL_BR;
        if (ir[24]) begin
          rf_ld    = 1'b1;
          rf_wsel  = 1'b1;
          alu_bsel = BSEL_PC;
          alu_op   = OP_MOV;
        end
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_arm_control_unit.sv
// Cycle-by-cycle check of arm_control_unit against a phase-level instruction model.
module tb_arm_control_unit;

  typedef struct packed {
    logic       ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, flags_ld;
    logic [1:0] pc_sel;
    logic       rf_wsel, rf_dsel;
    logic [3:0] alu_op;
    logic [1:0] alu_bsel;
    logic       mem_en, mem_rw, mem_byte;
    logic [3:0] state;
    logic       illegal;
  } obs_t;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        mem_ack;
  logic        ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, flags_ld;
  logic [1:0]  pc_sel;
  logic        rf_wsel, rf_dsel;
  logic [3:0]  alu_op;
  logic [1:0]  alu_bsel;
  logic        mem_en, mem_rw, mem_byte;
  logic [3:0]  state_o;
  logic        illegal;
  obs_t        obs;

  int n_checks = 0;
  int n_pass   = 0;

  arm_control_unit dut (
    .Clk(Clk), .Clr(Clr), .ir(ir), .flags(flags), .mem_ack(mem_ack),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
    .rf_ld(rf_ld), .flags_ld(flags_ld), .pc_sel(pc_sel), .rf_wsel(rf_wsel),
    .rf_dsel(rf_dsel), .alu_op(alu_op), .alu_bsel(alu_bsel), .mem_en(mem_en),
    .mem_rw(mem_rw), .mem_byte(mem_byte), .state_o(state_o), .illegal(illegal)
  );

  always #5 Clk = ~Clk;

  assign obs = {ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, flags_ld, pc_sel, rf_wsel,
                rf_dsel, alu_op, alu_bsel, mem_en, mem_rw, mem_byte, state_o, illegal};

  // ARM condition semantics: even codes test a predicate, odd codes invert it
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  task automatic check_now(input obs_t e, input string tag);
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: got %h expected %h (ir=%h flags=%b)", tag, obs, e, ir, flags);
  endtask

  task automatic step(input obs_t e, input logic ack, input string tag);
    @(negedge Clk);
    mem_ack = ack;
    #1;
    check_now(e, tag);
  endtask

  function automatic obs_t st(input int s);
    obs_t e;
    e = '0;
    e.state = 4'(s);
    return e;
  endfunction

  // Walks one instruction through the expected cycles; abort_mw>=0 asserts Clr
  // after that many unacknowledged data-wait cycles.
  task automatic run_instr(input logic [31:0] i, input logic [3:0] f,
                           input int fw, input int mw, input int abort_mw,
                           input string tag);
    obs_t e;
    logic dp, ls, br, nv, ok, is_cmp;
    dp = (i[27:26] == 2'b00);
    ls = (i[27:25] == 3'b010) && i[24];
    br = (i[27:25] == 3'b101);
    nv = (i[31:28] == 4'hF);
    ok = !nv && cond_ok(i[31:28], f);

    e = st(1); e.mar_ld = 1; e.alu_bsel = 2'b10;
    step(e, 1'($urandom_range(1)), {tag, ":fa"});
    ir = i; flags = f;
    for (int k = 0; k < fw; k++) begin
      e = st(2); e.mem_en = 1; e.mem_rw = 1;
      step(e, 1'b0, {tag, ":fw"});
    end
    e = st(2); e.mem_en = 1; e.mem_rw = 1; e.ir_ld = 1; e.pc_ld = 1;
    step(e, 1'b1, {tag, ":fack"});

    e = st(3);
    e.illegal = nv || (ok && !(dp || ls || br));
    step(e, 1'($urandom_range(1)), {tag, ":dec"});
    if (!ok || !(dp || ls || br)) return;

    if (dp) begin
      is_cmp = (i[24:23] == 2'b10);
      e = st(4); e.alu_op = i[24:21];
      e.rf_ld = !is_cmp; e.flags_ld = i[20] || is_cmp;
      step(e, 1'($urandom_range(1)), {tag, ":dp"});
    end else if (br) begin
      e = st(8); e.pc_ld = 1; e.pc_sel = 2'b01;
      if (i[24]) begin
        e.rf_ld = 1; e.rf_wsel = 1; e.alu_bsel = 2'b10; e.alu_op = 4'hD;
      end
      step(e, 1'($urandom_range(1)), {tag, ":br"});
    end else begin
      e = st(5); e.alu_op = i[23] ? 4'h4 : 4'h2; e.alu_bsel = 2'b01; e.mar_ld = 1;
      step(e, 1'($urandom_range(1)), {tag, ":ea"});
      e = st(6); e.mem_en = 1; e.mem_rw = i[20]; e.mem_byte = i[22]; e.mdr_ld = i[20];
      for (int k = 0; k < mw; k++) begin
        step(e, 1'b0, {tag, ":mw"});
        if (abort_mw >= 0 && k + 1 == abort_mw) begin
          #2 Clr = 1'b1;
          #1 check_now(st(0), {tag, ":async_clr"});
          step(st(0), 1'b1, {tag, ":clr_hold"});
          Clr = 1'b0;
          return;
        end
      end
      step(e, 1'b1, {tag, ":mack"});
      if (i[20]) begin
        e = st(7); e.rf_ld = 1; e.rf_dsel = 1;
        step(e, 1'($urandom_range(1)), {tag, ":wb"});
      end
    end
  endtask

  initial begin
    logic [31:0] ri;
    int          cls;
    Clr = 1'b1; mem_ack = 1'b1; ir = 32'h03B01001; flags = 4'b0000;
    step(st(0), 1'b1, "rst0");
    step(st(0), 1'b1, "rst1");
    Clr = 1'b0;

    run_instr(32'h03B01001, 4'b0000, 0, 0, -1, "moveqs_fail");
    run_instr(32'h03B01001, 4'b0100, 0, 0, -1, "moveqs_pass");
    run_instr(32'hE1510002, 4'b0000, 1, 0, -1, "cmp");
    run_instr(32'hE5912004, 4'b0000, 0, 3, -1, "ldr_wait3");
    run_instr(32'hE5812004, 4'b0000, 0, 0, -1, "str");
    run_instr(32'hE5C12004, 4'b0000, 2, 1, -1, "strb");
    run_instr(32'hEBFFFFFE, 4'b0000, 0, 0, -1, "bl");
    run_instr(32'hEAFFFFFE, 4'b0000, 0, 0, -1, "b");
    run_instr(32'hE7F000F0, 4'b0000, 0, 0, -1, "undef");
    run_instr(32'hF3A01001, 4'b0000, 0, 0, -1, "cond_nv");
    run_instr(32'hE5812004, 4'b0000, 0, 3, 2, "str_clr");

    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      cls = $urandom_range(4);
      case (cls)
        0: ri[27:26] = 2'b00;
        1: begin ri[27:25] = 3'b010; ri[24] = 1'b1; end
        2: ri[27:25] = 3'b101;
        3: ri[27:25] = 3'b011;
        default: ri[27:26] = 2'b11;
      endcase
      run_instr(ri, 4'($urandom_range(15)), $urandom_range(3), $urandom_range(3), -1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
